// File: rtl/riscv_v_reduct_accum.sv
// Vector reduction unit (vredsum/vredmax/vredmin style): it accumulates element-wise over beats,
// folds the accumulator with a pairwise tree, then combines the result with the scalar init.
module riscv_v_reduct_accum #(
  parameter int NUM_BYTES = 16,
  parameter int MAX_BEATS = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic [1:0]             op,
  input  logic                   is_signed,
  input  logic [1:0]             osize,
  input  logic [63:0]            init,
  input  logic [NUM_BYTES*8-1:0] data,
  input  logic [NUM_BYTES-1:0]   mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_BYTES*8-1:0] result,
  output logic                   beat_ovf
);

  localparam int W     = NUM_BYTES * 8;
  localparam int S_MAX = $clog2(NUM_BYTES);
  localparam int TW    = $clog2(S_MAX + 1);
  localparam int CW    = $clog2(MAX_BEATS + 2);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_BEATS + 1);

  typedef enum logic [2:0] {IDLE, ACCUM, TREE, FINAL, DONE} state_t;

  state_t          state, state_d;
  logic [W-1:0]    acc, result_q, beat_vec;
  logic [1:0]      op_q, sz_q, eff_op, eff_sz;
  logic            sgn_q, eff_sgn, accept;
  logic [63:0]     init_q;
  logic [CW-1:0]   beat_cnt;
  logic [TW-1:0]   tree_cnt, tree_s;

  function automatic logic [63:0] sew_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 64'hFF;
      2'd1:    return 64'hFFFF;
      2'd2:    return 64'hFFFF_FFFF;
      default: return '1;
    endcase
  endfunction

  // Widen to 65 bits so one signed compare serves both signed and unsigned elements.
  function automatic logic signed [64:0] ext(input logic [63:0] x, input logic sgn, input logic [1:0] sz);
    logic [63:0] m;
    logic [64:0] r;
    m = sew_mask(sz);
    r = {1'b0, x & m};
    if (sgn && x[(8 << sz) - 1]) r = {1'b1, x | ~m};
    return $signed(r);
  endfunction

  function automatic logic [63:0] elem_f(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] f_op, input logic sgn, input logic [1:0] sz);
    logic signed [64:0] ea, eb;
    ea = ext(a, sgn, sz);
    eb = ext(b, sgn, sz);
    case (f_op)
      2'b01:   return ((ea > eb) ? a : b) & sew_mask(sz);
      2'b10:   return ((ea < eb) ? a : b) & sew_mask(sz);
      default: return (a + b) & sew_mask(sz);
    endcase
  endfunction

  function automatic logic [63:0] identity(input logic [1:0] f_op, input logic sgn, input logic [1:0] sz);
    logic [63:0] m;
    m = sew_mask(sz);
    case (f_op)
      2'b01:   return sgn ? (m & ~(m >> 1)) : 64'b0;
      2'b10:   return sgn ? (m >> 1) : m;
      default: return 64'b0;
    endcase
  endfunction

  function automatic logic [63:0] get_elem(input logic [W-1:0] vec, input int k, input logic [1:0] sz);
    logic [W+63:0] pad;
    pad = {64'b0, vec};
    return pad[k * (8 << sz) +: 64] & sew_mask(sz);
  endfunction

  function automatic logic [W-1:0] put_elem(input logic [W-1:0] vec, input int k,
                                            input logic [63:0] val, input logic [1:0] sz);
    logic [W-1:0] r;
    r = vec;
    for (int b = 0; b < 8; b++)
      if (b < (1 << sz)) r[((k << sz) + b) * 8 +: 8] = val[b * 8 +: 8];
    return r;
  endfunction

  function automatic logic [W-1:0] load_vec(input logic [W-1:0] d, input logic [NUM_BYTES-1:0] mk,
                                            input logic [1:0] f_op, input logic sgn, input logic [1:0] sz);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_BYTES; k++)
      if (k < (NUM_BYTES >> sz))
        r = put_elem(r, k, mk[k << sz] ? get_elem(d, k, sz) : identity(f_op, sgn, sz), sz);
    return r;
  endfunction

  function automatic logic [W-1:0] step_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] f_op, input logic sgn, input logic [1:0] sz);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_BYTES; k++)
      if (k < (NUM_BYTES >> sz))
        r = put_elem(r, k, elem_f(get_elem(a, k, sz), get_elem(b, k, sz), f_op, sgn, sz), sz);
    return r;
  endfunction

  // Element k takes pair (2k, 2k+1); upper slots are never read again.
  function automatic logic [W-1:0] pair_vec(input logic [W-1:0] a, input logic [1:0] f_op,
                                            input logic sgn, input logic [1:0] sz);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_BYTES / 2; k++)
      if (k < ((NUM_BYTES >> sz) >> 1))
        r = put_elem(r, k, elem_f(get_elem(a, 2 * k, sz), get_elem(a, 2 * k + 1, sz), f_op, sgn, sz), sz);
    return r;
  endfunction

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign out_valid = (state == DONE);
  assign result    = result_q;
  assign accept    = in_valid && in_ready;
  assign eff_op    = in_first ? op : op_q;
  assign eff_sz    = in_first ? osize : sz_q;
  assign eff_sgn   = in_first ? is_signed : sgn_q;
  assign tree_s    = TW'(S_MAX) - TW'(eff_sz);
  assign beat_vec  = load_vec(data, mask, eff_op, eff_sgn, eff_sz);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept && in_first)
                 state_d = !in_last ? ACCUM : ((tree_s == '0) ? FINAL : TREE);
      ACCUM:   if (accept && in_last) state_d = (tree_s == '0) ? FINAL : TREE;
      TREE:    if (tree_cnt == '0) state_d = FINAL;
      FINAL:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      op_q     <= '0;
      sz_q     <= '0;
      sgn_q    <= 1'b0;
      init_q   <= '0;
      beat_cnt <= '0;
      beat_ovf <= 1'b0;
      tree_cnt <= '0;
      result_q <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE, ACCUM: begin
          if (accept && in_first) begin
            op_q     <= op;
            sz_q     <= osize;
            sgn_q    <= is_signed;
            init_q   <= init;
            acc      <= beat_vec;
            beat_cnt <= CW'(1);
            beat_ovf <= 1'b0;
            tree_cnt <= tree_s - TW'(1);
          end else if (accept && state == ACCUM) begin
            acc      <= step_vec(acc, beat_vec, op_q, sgn_q, sz_q);
            if (beat_cnt != CNT_SAT) beat_cnt <= beat_cnt + CW'(1);
            if (beat_cnt == CNT_SAT - CW'(1)) beat_ovf <= 1'b1;
            tree_cnt <= tree_s - TW'(1);
          end
        end
        // tree stage: one halving per cycle
        TREE: begin
          acc      <= pair_vec(acc, op_q, sgn_q, sz_q);
          tree_cnt <= tree_cnt - TW'(1);
        end
        // final stage: fold in the scalar operand
        FINAL: result_q <= W'(elem_f(get_elem(acc, 0, sz_q), init_q, op_q, sgn_q, sz_q));
        DONE:  if (out_ready) result_q <= '0;
        default: ;
      endcase
    end
  end

endmodule
